// File: rtl/dec_scan.sv
// dec_scan: registered N-to-2**N one-hot decoder.
// DIRECT mode decodes the external select w_i with one clock of latency.
// SCAN mode sweeps an internal index over every output. Each position is held for DWELL
// cycles, and the first BLANK cycles of each position are blanked.
// Intended for row/digit strobes on multiplexed displays and keypads.
module dec_scan #(
    parameter int unsigned N     = 3,
    parameter int unsigned DWELL = 4,
    parameter int unsigned BLANK = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               mode_i,   // 0 = DIRECT, 1 = SCAN
    input  logic [N-1:0]       w_i,
    output logic [0:(2**N)-1]  y_o,      // y_o[0] is the MSB
    output logic [N-1:0]       idx_o,
    output logic               wrap_o
);

    localparam int unsigned Outs = 2 ** N;
    // Keep the dwell counter at least one bit wide so DWELL=1 still elaborates cleanly.
    localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);
    localparam logic [N-1:0]    IdxLast = '1;

    // Reject parameter combinations the scan timing cannot honour.
    if (N == 0) begin : g_bad_n
        $error("dec_scan: N must be at least 1");
    end
    if (DWELL == 0) begin : g_bad_dwell
        $error("dec_scan: DWELL must be at least 1");
    end
    if (BLANK >= DWELL) begin : g_bad_blank
        $error("dec_scan: BLANK must be smaller than DWELL");
    end

    logic [N-1:0]      idx_q, idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [0:Outs-1]   y_q, y_d;
    logic              wrap_q, wrap_d;
    // Mode seen at the previous edge. It lets the first SCAN edge after DIRECT restart
    // the dwell count instead of advancing. Reset treats the block as having been DIRECT.
    logic              scan_q;
    logic              blank_d;

    // Index/dwell-counter/wrap next state for the edge being prepared.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (en_i) begin
            if (!mode_i) begin
                idx_d = w_i;
                cnt_d = '0;
            end else if (!scan_q) begin
                // Entering SCAN: keep the last decoded index and start a fresh dwell.
                cnt_d = '0;
            end else if (cnt_q == CntLast) begin
                cnt_d  = '0;
                idx_d  = idx_q + 1'b1;
                wrap_d = (idx_q == IdxLast);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Blanking window applies to the post-edge counter value.
    if (BLANK == 0) begin : g_no_blank
        assign blank_d = 1'b0;
    end else begin : g_blank
        localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK);
        assign blank_d = (cnt_d < BlankEnd);
    end

    // One-hot output from the post-edge index. DIRECT mode is never blanked.
    always_comb begin
        y_d = '0;
        if (en_i && (!mode_i || !blank_d)) begin
            y_d[idx_d] = 1'b1;
        end
    end

    // State registers; all outputs update together on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            y_q    <= '0;
            wrap_q <= 1'b0;
            scan_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
            wrap_q <= wrap_d;
            scan_q <= mode_i;
        end
    end

    assign y_o    = y_q;
    assign idx_o  = idx_q;
    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// Directed self-checking bench for dec_scan.
// u_dut uses N=3, DWELL=4, BLANK=1. u_dut1 uses N=3, DWELL=1, BLANK=0.
module tb_dec_scan;

    logic       clk;
    logic       rst;
    logic       en;
    logic       mode;
    logic [2:0] w;
    logic [0:7] y;
    logic [2:0] idx;
    logic       wrap;
    logic [0:7] y1;
    logic [2:0] idx1;
    logic       wrap1;

    int checks;
    int errors;

    dec_scan #(.N(3), .DWELL(4), .BLANK(1)) u_dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (en),
        .mode_i (mode),
        .w_i    (w),
        .y_o    (y),
        .idx_o  (idx),
        .wrap_o (wrap)
    );

    dec_scan #(.N(3), .DWELL(1), .BLANK(0)) u_dut1 (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (en),
        .mode_i (mode),
        .w_i    (w),
        .y_o    (y1),
        .idx_o  (idx1),
        .wrap_o (wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] oh(input int k);
        logic [7:0] v;
        v = 8'b1000_0000;
        return v >> k;
    endfunction

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset both DUTs, then apply the given mode/enable before release.
    task automatic do_reset(input logic m, input logic e);
        rst  = 1'b1;
        mode = m;
        en   = e;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b1);
        // Edge 23 of the scan: idx=5, cnt=2.
        repeat (23) tick();
        checks++;
        if (y !== 8'b0000_0100 || idx !== 3'd5) begin
            errors++;
            $display("FAIL reset_pre: y=%b idx=%0d, want y=00000100 idx=5", y, idx);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (y !== 8'b0 || idx !== 3'd0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: y=%b idx=%0d wrap=%b, want 0/0/0", y, idx, wrap);
        end
        repeat (2) tick();
        checks++;
        if (y !== 8'b0 || idx !== 3'd0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: y=%b idx=%0d wrap=%b, want 0/0/0", y, idx, wrap);
        end
        rst = 1'b0;
    endtask

    task automatic test_direct();
        do_reset(1'b0, 1'b0);
        w  = 3'b101;
        en = 1'b1;
        tick();
        checks++;
        if (y !== 8'b0000_0100 || idx !== 3'd5 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL direct_en: y=%b idx=%0d wrap=%b, want 00000100/5/0", y, idx, wrap);
        end
        en = 1'b0;
        w  = 3'b010;
        tick();
        checks++;
        if (y !== 8'b0 || idx !== 3'd5) begin
            errors++;
            $display("FAIL direct_dis: y=%b idx=%0d, want 00000000/5", y, idx);
        end
    endtask

    task automatic test_scan_sweep();
        logic [7:0] ey;
        int         p;
        do_reset(1'b1, 1'b1);
        for (int k = 1; k <= 34; k++) begin
            tick();
            p  = k - 1;
            ey = ((p % 4) < 1) ? 8'b0 : oh((p / 4) % 8);
            checks++;
            if (y !== ey || idx !== 3'((p / 4) % 8) || wrap !== (k == 33)) begin
                errors++;
                $display("FAIL sweep cycle %0d: y=%b idx=%0d wrap=%b, want %b/%0d/%b",
                         k, y, idx, wrap, ey, (p / 4) % 8, (k == 33));
            end
        end
    endtask

    task automatic test_pause();
        do_reset(1'b1, 1'b1);
        repeat (11) tick();  // idx=2, cnt=2
        checks++;
        if (y !== 8'b0010_0000 || idx !== 3'd2) begin
            errors++;
            $display("FAIL pause_pre: y=%b idx=%0d, want 00100000/2", y, idx);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (y !== 8'b0 || idx !== 3'd2 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold %0d: y=%b idx=%0d, want 0/2", i, y, idx);
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (y !== 8'b0010_0000 || idx !== 3'd2) begin
            errors++;
            $display("FAIL pause_resume: y=%b idx=%0d, want 00100000/2", y, idx);
        end
        tick();
        checks++;
        if (y !== 8'b0 || idx !== 3'd3) begin
            errors++;
            $display("FAIL pause_adv: y=%b idx=%0d, want 00000000/3", y, idx);
        end
        tick();
        checks++;
        if (y !== 8'b0001_0000 || idx !== 3'd3) begin
            errors++;
            $display("FAIL pause_adv2: y=%b idx=%0d, want 00010000/3", y, idx);
        end
    endtask

    task automatic test_mode_change();
        do_reset(1'b1, 1'b1);
        repeat (26) tick();  // idx=6, cnt=1
        checks++;
        if (y !== 8'b0000_0010 || idx !== 3'd6) begin
            errors++;
            $display("FAIL mode_pre: y=%b idx=%0d, want 00000010/6", y, idx);
        end
        mode = 1'b0;
        w    = 3'b001;
        tick();
        checks++;
        if (y !== 8'b0100_0000 || idx !== 3'd1 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL mode_to_direct: y=%b idx=%0d, want 01000000/1", y, idx);
        end
        mode = 1'b1;
        w    = 3'b111;
        tick();
        checks++;
        if (y !== 8'b0 || idx !== 3'd1 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL mode_to_scan: y=%b idx=%0d, want 00000000/1", y, idx);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (y !== 8'b0100_0000 || idx !== 3'd1) begin
                errors++;
                $display("FAIL mode_dwell %0d: y=%b idx=%0d, want 01000000/1", i, y, idx);
            end
        end
        tick();
        checks++;
        if (y !== 8'b0 || idx !== 3'd2) begin
            errors++;
            $display("FAIL mode_next: y=%b idx=%0d, want 00000000/2", y, idx);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] seq [8];
        seq = '{3'd7, 3'd0, 3'd3, 3'd6, 3'd1, 3'd4, 3'd2, 3'd5};
        do_reset(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            w = seq[i];
            tick();
            checks++;
            if (y !== oh(int'(seq[i])) || idx !== seq[i] || wrap !== 1'b0) begin
                errors++;
                $display("FAIL b2b %0d: y=%b idx=%0d wrap=%b, want %b/%0d/0",
                         i, y, idx, wrap, oh(int'(seq[i])), seq[i]);
            end
        end
    endtask

    task automatic test_dwell1();
        logic [7:0] ey;
        do_reset(1'b1, 1'b1);
        for (int k = 1; k <= 24; k++) begin
            tick();
            ey = oh((k - 1) % 8);
            checks++;
            if (y1 !== ey || idx1 !== 3'((k - 1) % 8) || wrap1 !== (k > 1 && (k - 1) % 8 == 0)
                || $countones(y1) != 1) begin
                errors++;
                $display("FAIL dwell1 cycle %0d: y=%b idx=%0d wrap=%b, want %b/%0d/%b",
                         k, y1, idx1, wrap1, ey, (k - 1) % 8, (k > 1 && (k - 1) % 8 == 0));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        en     = 1'b0;
        mode   = 1'b0;
        w      = 3'd0;
        #1;
        checks++;
        if (y !== 8'b0 || idx !== 3'd0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: y=%b idx=%0d wrap=%b, want 0/0/0", y, idx, wrap);
        end
        test_reset();
        test_direct();
        test_scan_sweep();
        test_pause();
        test_mode_change();
        test_back_to_back();
        test_dwell1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
